// File: rtl/watch_timekeeper.sv
// HH:MM:SS timekeeper with clock-enable prescaler, 12/24h display, range-checked loads and HH:MM alarm.
// Six registered digits drive segment7 decoders; everything runs on sysclk_i.

module segment7 (
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);
  // Active-high segments, bit order {g,f,e,d,c,b,a}.
  always_comb begin
    seg = 7'h00;
    if (!blank) begin
      case (digit)
        4'd0: seg = 7'h3F;
        4'd1: seg = 7'h06;
        4'd2: seg = 7'h5B;
        4'd3: seg = 7'h4F;
        4'd4: seg = 7'h66;
        4'd5: seg = 7'h6D;
        4'd6: seg = 7'h7D;
        4'd7: seg = 7'h07;
        4'd8: seg = 7'h7F;
        4'd9: seg = 7'h6F;
        default: seg = 7'h00;
      endcase
    end
  end
endmodule

module watch_timekeeper #(
  parameter int CLK_HZ   = 32768,
  parameter bit BLANK_LZ = 1'b1,
  parameter int ALARM_S  = 60
) (
  input  logic        sysclk_i,
  input  logic        rst_i,
  input  logic        smode_i,
  input  logic        dvalid_i,
  input  logic [16:0] cfg_i,
  input  logic        alarm_we_i,
  input  logic [10:0] alarm_i,
  input  logic        alarm_en_i,
  input  logic        alarm_ack_i,
  input  logic        mode12_i,
  output logic [6:0]  segment_hxxx,
  output logic [6:0]  segment_xhxx,
  output logic [6:0]  segment_xxmx,
  output logic [6:0]  segment_xxxm,
  output logic [6:0]  segment_sx,
  output logic [6:0]  segment_xs,
  output logic        pm_o,
  output logic        tick_1s_o,
  output logic        alarm_o,
  output logic        cfg_err_o
);
  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);

  logic [PW-1:0] presc_reg, presc_next;
  logic [4:0]    hh_reg, hh_next, ahh_reg, ahh_next;
  logic [5:0]    mm_reg, mm_next, ss_reg, ss_next, amm_reg, amm_next;
  logic [7:0]    ring_reg, ring_next;
  logic          alarm_reg, alarm_next;
  logic          tick_reg, tick_next;
  logic          err_reg, err_next;
  logic          past_smode_reg;

  logic smode_edge, tick_now, load_req, cfg_ok, alarm_ok, adv, fire;

  always_comb begin
    presc_next = presc_reg;
    hh_next    = hh_reg;
    mm_next    = mm_reg;
    ss_next    = ss_reg;
    ahh_next   = ahh_reg;
    amm_next   = amm_reg;
    ring_next  = ring_reg;
    alarm_next = alarm_reg;
    err_next   = 1'b0;
    adv        = 1'b0;
    fire       = 1'b0;

    smode_edge = (smode_i != past_smode_reg);
    tick_now   = (presc_reg == PRESC_MAX);
    load_req   = dvalid_i && !smode_i && !smode_edge;
    cfg_ok     = (cfg_i[16:12] <= 5'd23) && (cfg_i[11:6] <= 6'd59) && (cfg_i[5:0] <= 6'd59);
    alarm_ok   = (alarm_i[10:6] <= 5'd23) && (alarm_i[5:0] <= 6'd59);

    if (smode_edge) begin
      hh_next    = 5'd0;
      mm_next    = 6'd0;
      ss_next    = 6'd0;
      presc_next = '0;
    end else if (load_req && cfg_ok) begin
      // A load on the tick cycle restarts the second, so that tick is dropped.
      hh_next    = cfg_i[16:12];
      mm_next    = cfg_i[11:6];
      ss_next    = cfg_i[5:0];
      presc_next = '0;
    end else begin
      presc_next = tick_now ? '0 : presc_reg + PW'(1);
      if (tick_now) begin
        adv = 1'b1;
        if (ss_reg == 6'd59) begin
          ss_next = 6'd0;
          if (mm_reg == 6'd59) begin
            mm_next = 6'd0;
            hh_next = (hh_reg == 5'd23) ? 5'd0 : hh_reg + 5'd1;
          end else begin
            mm_next = mm_reg + 6'd1;
          end
        end else begin
          ss_next = ss_reg + 6'd1;
        end
      end
    end

    if (load_req && !cfg_ok)
      err_next = 1'b1;

    if (alarm_we_i && !smode_i) begin
      if (alarm_ok) begin
        ahh_next = alarm_i[10:6];
        amm_next = alarm_i[5:0];
      end else begin
        err_next = 1'b1;
      end
    end

    // Only a counted second can fire the alarm, never a load.
    fire = alarm_en_i && adv && (hh_next == ahh_reg) && (mm_next == amm_reg) && (ss_next == 6'd0);

    if (!alarm_en_i || alarm_ack_i || smode_edge) begin
      alarm_next = 1'b0;
      ring_next  = 8'd0;
    end else if (fire) begin
      alarm_next = 1'b1;
      ring_next  = 8'(ALARM_S);
    end else if (alarm_reg && adv) begin
      ring_next = ring_reg - 8'd1;
      if (ring_reg <= 8'd1) begin
        alarm_next = 1'b0;
        ring_next  = 8'd0;
      end
    end

    tick_next = adv;
  end

  always_ff @(posedge sysclk_i) begin
    if (rst_i) begin
      presc_reg      <= '0;
      hh_reg         <= 5'd0;
      mm_reg         <= 6'd0;
      ss_reg         <= 6'd0;
      ahh_reg        <= 5'd0;
      amm_reg        <= 6'd0;
      ring_reg       <= 8'd0;
      alarm_reg      <= 1'b0;
      tick_reg       <= 1'b0;
      err_reg        <= 1'b0;
      past_smode_reg <= 1'b0;
    end else begin
      presc_reg      <= presc_next;
      hh_reg         <= hh_next;
      mm_reg         <= mm_next;
      ss_reg         <= ss_next;
      ahh_reg        <= ahh_next;
      amm_reg        <= amm_next;
      ring_reg       <= ring_next;
      alarm_reg      <= alarm_next;
      tick_reg       <= tick_next;
      err_reg        <= err_next;
      past_smode_reg <= smode_i;
    end
  end

  assign tick_1s_o = tick_reg;
  assign alarm_o   = alarm_reg;
  assign cfg_err_o = err_reg;
  assign pm_o      = mode12_i && (hh_reg >= 5'd12);

  logic [4:0] disp_hh;
  logic [3:0] digit [6];
  logic [6:0] seg [6];

  always_comb begin
    disp_hh = hh_reg;
    if (mode12_i) begin
      if (hh_reg == 5'd0)
        disp_hh = 5'd12;
      else if (hh_reg > 5'd12)
        disp_hh = hh_reg - 5'd12;
    end
    digit[0] = 4'(disp_hh / 5'd10);
    digit[1] = 4'(disp_hh % 5'd10);
    digit[2] = 4'(mm_reg / 6'd10);
    digit[3] = 4'(mm_reg % 6'd10);
    digit[4] = 4'(ss_reg / 6'd10);
    digit[5] = 4'(ss_reg % 6'd10);
  end

  generate
    for (genvar gi = 0; gi < 6; gi++) begin : g_seg
      segment7 u_seg (
        .digit (digit[gi]),
        .blank ((gi == 0) ? (BLANK_LZ && (digit[gi] == 4'd0)) : 1'b0),
        .seg   (seg[gi])
      );
    end
  endgenerate

  assign segment_hxxx = seg[0];
  assign segment_xhxx = seg[1];
  assign segment_xxmx = seg[2];
  assign segment_xxxm = seg[3];
  assign segment_sx   = seg[4];
  assign segment_xs   = seg[5];
endmodule

// File: tb/tb_watch_timekeeper.sv
// Directed bench for watch_timekeeper: load/display vector table plus hand-written
// sequences for reset, prescaler, rollover, safe mode, tick/load collision and alarm.

module tb_watch_timekeeper;
  localparam logic [6:0] S0 = 7'h3F, S1 = 7'h06, S2 = 7'h5B, S3 = 7'h4F, S4 = 7'h66;
  localparam logic [6:0] S5 = 7'h6D, S6 = 7'h7D, S7 = 7'h07, S8 = 7'h7F, S9 = 7'h6F;
  localparam logic [6:0] BL = 7'h00;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1, smode_i = 1'b0, dvalid_i = 1'b0;
  logic [16:0] cfg_i = '0;
  logic        alarm_we_i = 1'b0, alarm_en_i = 1'b0, alarm_ack_i = 1'b0, mode12_i = 1'b0;
  logic [10:0] alarm_i = '0;
  logic [6:0]  segment_hxxx, segment_xhxx, segment_xxmx, segment_xxxm, segment_sx, segment_xs;
  logic        pm_o, tick_1s_o, alarm_o, cfg_err_o;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  watch_timekeeper #(.CLK_HZ(4), .BLANK_LZ(1'b1), .ALARM_S(3)) dut (
    .sysclk_i     (clk),
    .rst_i        (rst_i),
    .smode_i      (smode_i),
    .dvalid_i     (dvalid_i),
    .cfg_i        (cfg_i),
    .alarm_we_i   (alarm_we_i),
    .alarm_i      (alarm_i),
    .alarm_en_i   (alarm_en_i),
    .alarm_ack_i  (alarm_ack_i),
    .mode12_i     (mode12_i),
    .segment_hxxx (segment_hxxx),
    .segment_xhxx (segment_xhxx),
    .segment_xxmx (segment_xxmx),
    .segment_xxxm (segment_xxxm),
    .segment_sx   (segment_sx),
    .segment_xs   (segment_xs),
    .pm_o         (pm_o),
    .tick_1s_o    (tick_1s_o),
    .alarm_o      (alarm_o),
    .cfg_err_o    (cfg_err_o)
  );

  typedef struct {
    logic        mode12;
    logic [16:0] cfg;
    logic [41:0] seg;
    logic        pm;
    logic        err;
  } vec_t;

  vec_t tbl [12];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got %h want %h", name, got, want);
    end else begin
      $display("ok   %s = %h", name, got);
    end
  endtask

  function automatic logic [41:0] disp();
    return {segment_hxxx, segment_xhxx, segment_xxmx, segment_xxxm, segment_sx, segment_xs};
  endfunction

  task automatic load(input logic [4:0] hh, input logic [5:0] mm, input logic [5:0] ss);
    cfg_i = {hh, mm, ss};
    dvalid_i = 1'b1;
    cyc();
    dvalid_i = 1'b0;
  endtask

  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (tick_1s_o) begin
        seen = 1'b1;
        break;
      end
    end
    chk({name, " tick seen"}, 64'(seen), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{1'b0, {5'd13, 6'd5,  6'd0 }, {S1, S3, S0, S5, S0, S0}, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, {5'd13, 6'd5,  6'd0 }, {BL, S1, S0, S5, S0, S0}, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, {5'd0,  6'd0,  6'd0 }, {S1, S2, S0, S0, S0, S0}, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, {5'd24, 6'd0,  6'd0 }, {BL, S0, S0, S0, S0, S0}, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, {5'd23, 6'd59, 6'd58}, {S2, S3, S5, S9, S5, S8}, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, {5'd12, 6'd60, 6'd0 }, {S2, S3, S5, S9, S5, S8}, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, {5'd12, 6'd34, 6'd56}, {S1, S2, S3, S4, S5, S6}, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, {5'd1,  6'd2,  6'd3 }, {BL, S1, S0, S2, S0, S3}, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, {5'd5,  6'd5,  6'd60}, {BL, S1, S0, S2, S0, S3}, 1'b0, 1'b1};
    tbl[9]  = '{1'b0, {5'd9,  6'd7,  6'd45}, {BL, S9, S0, S7, S4, S5}, 1'b0, 1'b0};
    tbl[10] = '{1'b1, {5'd23, 6'd0,  6'd0 }, {S1, S1, S0, S0, S0, S0}, 1'b1, 1'b0};
    tbl[11] = '{1'b0, {5'd20, 6'd10, 6'd1 }, {S2, S0, S1, S0, S0, S1}, 1'b0, 1'b0};

    // Reset and prescaler cadence
    cyc();
    cyc();
    chk("reset disp", 64'(disp()), 64'({BL, S0, S0, S0, S0, S0}));
    chk("reset tick", 64'(tick_1s_o), 64'd0);
    chk("reset alarm", 64'(alarm_o), 64'd0);
    chk("reset err", 64'(cfg_err_o), 64'd0);
    mode12_i = 1'b1;
    #1;
    chk("reset disp 12h", 64'(disp()), 64'({S1, S2, S0, S0, S0, S0}));
    mode12_i = 1'b0;
    rst_i = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      cyc();
      chk($sformatf("tick cycle %0d", c), 64'(tick_1s_o), 64'((c % 4) == 0));
    end
    chk("3 ticks disp", 64'(disp()), 64'({BL, S0, S0, S0, S0, S3}));

    // Load/display table, applied back to back so no tick intervenes
    for (int i = 0; i < 12; i++) begin
      mode12_i = tbl[i].mode12;
      load(tbl[i].cfg[16:12], tbl[i].cfg[11:6], tbl[i].cfg[5:0]);
      chk($sformatf("vec%0d seg", i), 64'(disp()), 64'(tbl[i].seg));
      chk($sformatf("vec%0d pm", i), 64'(pm_o), 64'(tbl[i].pm));
      chk($sformatf("vec%0d err", i), 64'(cfg_err_o), 64'(tbl[i].err));
    end
    mode12_i = 1'b0;

    // Midnight rollover
    load(5'd23, 6'd59, 6'd58);
    wait_tick("roll1");
    chk("roll 23:59:59", 64'(disp()), 64'({S2, S3, S5, S9, S5, S9}));
    wait_tick("roll2");
    chk("roll 00:00:00", 64'(disp()), 64'({BL, S0, S0, S0, S0, S0}));
    chk("roll pm", 64'(pm_o), 64'd0);

    // Tick coinciding with a load: the load wins and the tick is dropped
    load(5'd5, 6'd0, 6'd0);
    cyc();
    cyc();
    cyc();
    load(5'd6, 6'd6, 6'd6);
    chk("collide disp", 64'(disp()), 64'({BL, S6, S0, S6, S0, S6}));
    chk("collide tick", 64'(tick_1s_o), 64'd0);

    // Safe mode edges
    load(5'd10, 6'd20, 6'd30);
    cyc();
    smode_i = 1'b1;
    cyc();
    chk("smode rise", 64'(disp()), 64'({BL, S0, S0, S0, S0, S0}));
    load(5'd24, 6'd0, 6'd0);
    chk("smode load ignored", 64'(disp()), 64'({BL, S0, S0, S0, S0, S0}));
    chk("smode no err", 64'(cfg_err_o), 64'd0);
    wait_tick("smode");
    chk("smode counts", 64'(disp()), 64'({BL, S0, S0, S0, S0, S1}));
    smode_i = 1'b0;
    cyc();
    chk("smode fall", 64'(disp()), 64'({BL, S0, S0, S0, S0, S0}));

    // Alarm: bad alarm value, load onto alarm time, fire, ring out, ack
    alarm_i = {5'd24, 6'd0};
    alarm_we_i = 1'b1;
    cyc();
    alarm_we_i = 1'b0;
    chk("alarm bad err", 64'(cfg_err_o), 64'd1);
    alarm_en_i = 1'b1;
    alarm_i = {5'd7, 6'd30};
    alarm_we_i = 1'b1;
    load(5'd7, 6'd30, 6'd0);
    alarm_we_i = 1'b0;
    chk("alarm load no fire", 64'(alarm_o), 64'd0);
    wait_tick("alarm idle");
    chk("alarm still idle", 64'(alarm_o), 64'd0);
    load(5'd7, 6'd29, 6'd59);
    wait_tick("alarm fire");
    chk("alarm fired", 64'(alarm_o), 64'd1);
    wait_tick("ring1");
    chk("ring1", 64'(alarm_o), 64'd1);
    wait_tick("ring2");
    chk("ring2", 64'(alarm_o), 64'd1);
    wait_tick("ring3");
    chk("ring expired", 64'(alarm_o), 64'd0);
    load(5'd7, 6'd29, 6'd59);
    wait_tick("refire");
    chk("alarm refired", 64'(alarm_o), 64'd1);
    cyc();
    alarm_ack_i = 1'b1;
    cyc();
    alarm_ack_i = 1'b0;
    chk("alarm ack", 64'(alarm_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
